mem_arbiter_n: RTL and testbench
================================

# mem_arbiter_n

Parametrised N-port memory arbiter between the cache-side requesters (icache, dcache, prefetcher, …) and the single cacheline adapter. It grants one requester at a time, registers the granted request so the adapter sees stable signals for the whole transaction, and routes the response back to the owner. Arbitration is round-robin by default, or fixed-priority when compiled without the round-robin macro. It replaces the two-port, pass-through arbiter in the memory hierarchy.

## Interface
- NUM_PORTS, 2, number of requesters (2..8); port 0 is the icache by convention.
- ADDR_W, 32, address width.
- LINE_W, 256, cacheline width.
- IDX_W, $clog2(NUM_PORTS) (minimum 1), width of the grant index.
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- req_addr  input  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_read  input  NUM_PORTS  per-port read request.
- req_write  input  NUM_PORTS  per-port write request.
- req_wdata  input  NUM_PORTS*LINE_W  per-port write line; same packing as req_addr.
- resp  output  NUM_PORTS  one-cycle completion pulse to the owner.
- resp_rdata  output  LINE_W  read line, broadcast to all ports; valid only with resp[i].
- mem_addr  output  ADDR_W  adapter address.
- mem_read  output  1  adapter read.
- mem_write  output  1  adapter write.
- mem_wdata  output  LINE_W  adapter write line.
- mem_rdata  input  LINE_W  adapter read line.
- mem_resp  input  1  adapter completion.
- busy  output  1  a transaction is outstanding.
- grant_idx  output  IDX_W  current or most recent owner.

## Operation
- States:
  - IDLE: arbitrate. If any port has req_read|req_write, select a winner, latch its addr/wdata/op and index, then go to BUSY.
  - BUSY: drive mem_* from the latched registers. When mem_resp is seen, pulse resp[owner], drive resp_rdata=mem_rdata combinationally, and go to IDLE.
- Port i requests when req_read[i]|req_write[i]. If both are set, the request is treated as a write; this is illegal stimulus but the behaviour is defined.
- Requesters hold their request until they see resp[i], and drop it in the following cycle. The arbiter does not track saved requests; a held request is the pending state.
- Round-robin (MEM_ARB_RR_EN): the search starts at (last_grant+1) mod NUM_PORTS and takes the first requester found. last_grant updates when the request is latched.
- mem_read/mem_write are 0 in IDLE. mem_addr and mem_wdata hold their last latched values.
- mem_resp in IDLE is ignored.
- Latched registers do not change in BUSY, even if the owner alters its inputs.
- busy=1 iff state==BUSY.

## Timing
- Reset values:
  - state=IDLE; resp=0; resp_rdata=0 (mux gated by resp).
  - mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0.
  - busy=0; grant_idx=0; last_grant=NUM_PORTS-1, so port 0 wins first.
- Request in IDLE at cycle c: mem_read/mem_write is asserted in cycle c+1.
- mem_resp in cycle d: resp[owner]=1 in cycle d (combinational), state=IDLE in d+1. The earliest next grant latches at the end of d+1, and mem_* is asserted in d+2. This gives one idle bubble between transactions.
- Owner's request still high in cycle d: ignored, because arbitration happens only in IDLE.
- Reset in BUSY: state=IDLE next cycle and mem_read/mem_write drop. The adapter is reset by the same rst; a stale mem_resp is ignored.
- Simultaneous requests from all ports: exactly one grant per IDLE cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration with the last_grant pointer.
- MEM_ARB_RR_EN undefined: fixed priority, lowest index wins; the last_grant register is not built, and grant_idx still reports the owner.

## Test plan
- Reset: assert rst for 2 cycles with all requests high -> mem_read=mem_write=0, resp=0, busy=0 during reset; port 0 is granted first after release.
- Single read, NUM_PORTS=2: port 1 reads 0x0000_1040, adapter responds 5 cycles after mem_read with line 0xA5…A5 -> mem_addr=0x1040, resp=2'b10 for one cycle, resp_rdata=0xA5…A5.
- Contention, NUM_PORTS=4, RR_EN: all four ports request continuously -> grant order 0,1,2,3,0; without the macro -> 0,0,0,… while port 0 holds its request.
- Latch stability: owner changes req_addr from 0x100 to 0x200 during BUSY -> mem_addr stays 0x100 until resp.
- Write: port 0 has read=write=1 with wdata=0xDEAD…; -> mem_write=1, mem_read=0, mem_wdata=0xDEAD….
- Reset mid-BUSY: rst in cycle 3 of a read -> mem_read=0 next cycle; a late mem_resp produces no resp pulse.

Source files
------------

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port cacheline arbiter that latches the granted request and routes the response back.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mem_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int IDX_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        resp,
  output logic [LINE_W-1:0]           resp_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_resp,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_idx
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic r_write;
  logic [IDX_W-1:0] r_owner, w_win;
  logic [NUM_PORTS-1:0] w_req;
  logic w_grant;
  assign w_req = req_read | req_write;
  assign w_grant = (r_state == IDLE) && |w_req;
`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] r_last, w_cand;
  logic w_found;
  // Search begins just past the previous owner so every requester is eventually served.
  always_comb begin
    w_win = '0;
    w_cand = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % NUM_PORTS);
      if (!w_found && w_req[w_cand]) begin
        w_win = w_cand;
        w_found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) r_last <= IDX_W'(NUM_PORTS - 1);
    else if (w_grant) r_last <= w_win;
`else
  always_comb begin
    w_win = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (w_req[k]) w_win = IDX_W'(k);
  end
`endif
  always_comb w_next = (r_state == IDLE) ? (|w_req ? BUSY : IDLE) : (mem_resp ? IDLE : BUSY);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_owner <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_addr <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
        r_wdata <= req_wdata[int'(w_win)*LINE_W +: LINE_W];
        r_write <= req_write[w_win];
        r_owner <= w_win;
      end
    end
  end
  assign busy = (r_state == BUSY);
  assign mem_read = busy && !r_write;
  assign mem_write = busy && r_write;
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  assign grant_idx = r_owner;
  assign resp = (busy && mem_resp) ? NUM_PORTS'(1) << r_owner : '0;
  assign resp_rdata = |resp ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: scoreboard bench; predicted grants are queued as requests are driven and popped as the adapter sees them.
module tb_mem_arbiter_n;
  localparam int N = 4, AW = 32, LW = 256, IW = 2;
  logic clk = 0, rst = 1;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0] req_read = '0, req_write = '0, resp;
  logic [N*LW-1:0] req_wdata = '0;
  logic [LW-1:0] resp_rdata, mem_wdata, mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic mem_read, mem_write, mem_resp = 0, busy;
  logic [IW-1:0] grant_idx;
  typedef struct {int port; logic [AW-1:0] addr; logic [LW-1:0] wdata; logic wr;} txn_t;
  txn_t sb[$];
  int n_cmp = 0, n_err = 0, m_last = N - 1;

  mem_arbiter_n #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_read(req_read), .req_write(req_write),
    .req_wdata(req_wdata), .resp(resp), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .busy(busy), .grant_idx(grant_idx));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int predict(input logic [N-1:0] r);
`ifdef MEM_ARB_RR_EN
    for (int k = 1; k <= N; k++) if (r[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction

  task automatic push_expect();
    txn_t t;
    int p;
    p = predict(req_read | req_write);
    t.port = p;
    t.addr = req_addr[p*AW +: AW];
    t.wdata = req_wdata[p*LW +: LW];
    t.wr = req_write[p];
    sb.push_back(t);
    m_last = p;
  endtask

  // Adapter model: expects the grant one cycle after the request, answers after lat cycles.
  task automatic run_txn(input int lat, input logic [LW-1:0] line, input bit hold, input bit perturb);
    txn_t e;
    int t;
    @(negedge clk);
    t = 1;
    while (!(mem_read || mem_write) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("grant_latency", t, 1);
    if (t >= 20 || sb.size() == 0) begin
      chk("sb_underflow_or_timeout", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("grant_idx", grant_idx, e.port);
    chk("mem_addr", mem_addr, e.addr);
    chk("mem_read", mem_read, !e.wr);
    chk("mem_write", mem_write, e.wr);
    if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
    chk("busy", busy, 1);
    if (perturb) req_addr[e.port*AW +: AW] = e.addr + 32'h100;
    repeat (lat - 1) begin
      @(negedge clk);
      chk("addr_stable", mem_addr, e.addr);
      chk("resp_early", resp, 0);
    end
    @(negedge clk);
    mem_rdata = line;
    mem_resp = 1;
    #1;
    chk("resp", resp, 1 << e.port);
    chk("resp_rdata", resp_rdata, line);
    @(negedge clk);
    mem_resp = 0;
    if (!hold) begin
      req_read = '0;
      req_write = '0;
    end
    #1;
    chk("resp_off", resp, 0);
    chk("bubble", {busy, mem_read, mem_write}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req_read = '1;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'h400 + 32'(i) * 32'h40;
    repeat (2) begin
      @(negedge clk);
      chk("rst_rw", {mem_read, mem_write}, 0);
      chk("rst_resp", resp, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_idx, 0);
      chk("rst_addr", mem_addr, 0);
    end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      push_expect();
      run_txn(2, {8{$urandom()}}, i < 4, 0);
    end
    req_read[1] = 1;
    req_addr[1*AW +: AW] = 32'h0000_1040;
    push_expect();
    run_txn(5, {32{8'hA5}}, 0, 0);
    req_read[2] = 1;
    req_addr[2*AW +: AW] = 32'h100;
    push_expect();
    run_txn(4, {8{$urandom()}}, 0, 1);
    req_read[0] = 1;
    req_write[0] = 1;
    req_addr[0 +: AW] = 32'h2000;
    req_wdata[0 +: LW] = {8{32'hDEAD_BEEF}};
    push_expect();
    run_txn(3, {8{$urandom()}}, 0, 0);
    req_read[3] = 1;
    req_addr[3*AW +: AW] = 32'h3000;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_pre", mem_read, 1);
    @(negedge clk);
    rst = 1;
    req_read = '0;
    @(negedge clk);
    chk("mid_rst_rd", mem_read, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_idx, 0);
    rst = 0;
    m_last = N - 1;
    mem_resp = 1;
    #1;
    chk("stale_resp", resp, 0);
    @(negedge clk);
    mem_resp = 0;
    chk("stale_busy", busy, 0);
    req_read[2] = 1;
    req_read[3] = 1;
    req_addr[2*AW +: AW] = 32'h5000;
    push_expect();
    run_txn(2, {8{$urandom()}}, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
